// File: rtl/cpu_if_reg_responder.sv
// Target end of the cpu_if read/write pulse protocol: small control/status register bank
// with fixed-latency completion. Define CPU_IF_ERR_CNT_EN to add ERROR_COUNT at offset 0x10.
module cpu_if_reg_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE       = 32'h5453_0001,
    parameter logic [31:0] CTRL_RESET     = 32'h0000_0000,
    parameter int          ACCESS_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_if_read,
    input  logic        cpu_if_write,
    input  logic [31:0] cpu_if_write_data,
    input  logic [31:2] cpu_if_address,
    output logic [31:0] cpu_if_read_data,
    output logic        cpu_if_access_complete,
    output logic [31:0] ctrl_reg,
    input  logic [30:0] hw_status_set,
    output logic [31:0] status_reg
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] LOAD = 4'(ACCESS_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] scratch;

    logic        req, fire, overrun;
    logic        cur_wr;
    logic [31:2] cur_addr;
    logic [31:0] cur_wdata;
    logic        hit, mapped, sel_scratch, sel_ctrl, sel_status;
    logic [31:0] rd_val, clr_vec, set_vec;

    assign req     = cpu_if_read | cpu_if_write;
    assign overrun = req && (state != IDLE);

    // With a latency of 1 the access resolves on the accepting edge, so the
    // not-yet-latched request inputs feed the decode directly.
    assign fire = (state == IDLE && req && LOAD == 4'd0) ||
                  (state == WAIT && cnt == 4'd1);
    assign cur_wr    = (state == IDLE) ? cpu_if_write      : wr_q;
    assign cur_addr  = (state == IDLE) ? cpu_if_address    : addr_q;
    assign cur_wdata = (state == IDLE) ? cpu_if_write_data : wdata_q;

    assign hit = (cur_addr[31:8] == BASE_ADDR[31:8]);

`ifdef CPU_IF_ERR_CNT_EN
    logic [31:0] err_cnt;
`endif

    always_comb begin
        rd_val      = 32'hDEAD_BEEF;
        mapped      = 1'b0;
        sel_scratch = 1'b0;
        sel_ctrl    = 1'b0;
        sel_status  = 1'b0;
        if (hit) begin
            case (cur_addr[7:2])
                6'h00: begin mapped = 1'b1; rd_val = ID_VALUE; end
                6'h01: begin mapped = 1'b1; rd_val = scratch;    sel_scratch = 1'b1; end
                6'h02: begin mapped = 1'b1; rd_val = ctrl_reg;   sel_ctrl    = 1'b1; end
                6'h03: begin mapped = 1'b1; rd_val = status_reg; sel_status  = 1'b1; end
`ifdef CPU_IF_ERR_CNT_EN
                6'h04: begin mapped = 1'b1; rd_val = err_cnt; end
`endif
                default: ;
            endcase
        end
    end

    // Set wins over a coincident W1C clear; bit 31 is set by overruns.
    assign clr_vec = (fire && cur_wr && sel_status) ? cur_wdata : 32'h0;
    assign set_vec = {overrun, hw_status_set};

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            cnt                    <= 4'd0;
            wr_q                   <= 1'b0;
            addr_q                 <= '0;
            wdata_q                <= 32'h0;
            scratch                <= 32'h0;
            ctrl_reg               <= CTRL_RESET;
            status_reg             <= 32'h0;
            cpu_if_read_data       <= 32'h0;
            cpu_if_access_complete <= 1'b0;
        end else begin
            cpu_if_access_complete <= fire;
            status_reg             <= (status_reg & ~clr_vec) | set_vec;

            if (fire) begin
                if (cur_wr) begin
                    if (sel_scratch) scratch  <= cur_wdata;
                    if (sel_ctrl)    ctrl_reg <= cur_wdata;
                end else begin
                    cpu_if_read_data <= rd_val;
                end
            end

            case (state)
                IDLE: if (req) begin
                    wr_q    <= cpu_if_write;
                    addr_q  <= cpu_if_address;
                    wdata_q <= cpu_if_write_data;
                    cnt     <= LOAD;
                    state   <= (LOAD == 4'd0) ? ACK : WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd1) state <= ACK;
                    else             cnt   <= cnt - 4'd1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_IF_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= 32'h0;
        else if (fire && !mapped && err_cnt != 32'hFFFF_FFFF)
            err_cnt <= err_cnt + 32'd1;
    end
`endif

endmodule
